mem_ls_stage: RTL and testbench
===============================

Name: mem_ls_stage

Overview:
- Next-generation MEM pipeline stage for the openMIPS core. Sits between the EX/MEM and MEM/WB pipeline registers.
- Passes ALU/HI-LO results through. Adds real load/store execution over a req/ack data bus with wait states.
- Handles byte-lane selection and sign/zero extension, misalignment detection and a bus timeout.
- Stalls the pipeline while an access is outstanding.

Parameters:
- ADDR_W, 32, data-bus address width.
- REG_ADDR_W, 5, register-file address width.
- MAX_WAIT, 15, maximum cycles spent in WAIT before timeout. Range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wdata_i  in  32  EX result
- wd_i  in  REG_ADDR_W  destination register
- wreg_i  in  1  register write enable
- whilo_i  in  1  HI/LO write enable
- hi_i  in  32  HI value
- lo_i  in  32  LO value
- mem_op_i  in  4  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW; 9-15 treated as none
- mem_addr_i  in  ADDR_W  effective address
- store_data_i  in  32  store source (rt)
- wdata_o  out  32  writeback data
- wd_o  out  REG_ADDR_W  destination register
- wreg_o  out  1  register write enable
- whilo_o  out  1  HI/LO write enable
- hi_o  out  32  HI value
- lo_o  out  32  LO value
- mem_req_o  out  1  bus request, registered
- mem_we_o  out  1  bus write, registered
- mem_addr_o  out  ADDR_W  word-aligned address (low 2 bits 0), registered
- mem_sel_o  out  4  byte-lane enables, registered
- mem_data_o  out  32  store data replicated to lanes, registered
- mem_ack_i  in  1  bus acknowledge (single cycle)
- mem_data_i  in  32  bus read data, valid with ack
- stall_req_o  out  1  pipeline stall request
- adel_o  out  1  load address error
- ades_o  out  1  store address error
- bus_err_o  out  1  timeout, one-cycle pulse in DONE

Behaviour:
- Reset (rst=1 at posedge):
  - FSM -> IDLE; wait counter = 0.
  - mem_req_o, mem_we_o = 0; mem_addr_o, mem_sel_o, mem_data_o = 0; captured read data = 0.
  - While rst is high, all combinational outputs are forced: wdata_o/hi_o/lo_o = 0, wd_o = 0, wreg_o/whilo_o = 0, stall_req_o/adel_o/ades_o/bus_err_o = 0.
  - Reset mid-access drops mem_req_o at that edge. A late ack is ignored in IDLE.
- Misalignment (combinational):
  - Half-word op with addr[0]=1, or word op with addr[1:0]!=0, is misaligned.
  - Misaligned load: adel_o=1, wreg_o=0. Misaligned store: ades_o=1.
  - No bus access, no stall, FSM stays IDLE.
- Lanes are big-endian:
  - addr[1:0]=0 selects bits [31:24], sel 4'b1000. addr=3 selects bits [7:0], sel 4'b0001.
  - Half-word: addr[1]=0 -> sel 4'b1100; addr[1]=1 -> sel 4'b0011. Word -> 4'b1111.
  - Store data: SB replicates byte x4, SH replicates half x2, SW as-is.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: an aligned mem op registers the bus fields, sets mem_req_o=1, clears the counter, -> WAIT. stall_req_o=1 combinationally in that cycle.
  - WAIT: mem_req_o and all bus fields held stable; stall_req_o=1; counter increments.
    - ack=1: capture mem_data_i, req->0, -> DONE.
    - Counter reaches MAX_WAIT without ack: req->0, timeout flag set, -> DONE.
  - DONE: stall_req_o=0 (pipeline advances at this edge). bus_err_o = timeout flag. -> IDLE unconditionally. The next cycle holds a new instruction, so the same op is never reissued.
- Writeback data:
  - Non-mem ops: wdata_o = wdata_i.
  - Loads: wdata_o = captured lane, sign-extended (LB/LH) or zero-extended (LBU/LHU), valid in DONE. On timeout, load wreg_o=0.
- Pass-through: wd_o, whilo_o, hi_o, lo_o follow inputs unchanged in every state when rst=0.
- Minimum load/store latency: 3 cycles (IDLE, WAIT with immediate ack, DONE). Each extra wait state adds 1.

Test Plan:
- Pass-through: mem_op_i=0, wdata_i=0x12345678, wd_i=5, wreg_i=1, whilo_i=1, hi_i=0xA, lo_i=0xB -> outputs equal inputs same cycle; stall_req_o=0; mem_req_o stays 0.
- LB addr=0x1003, ack after 2 wait cycles with mem_data_i=0x000000F0 -> mem_addr_o=0x1000, sel=0001; stall held 3 cycles; in DONE wdata_o=0xFFFFFFF0, wreg_o=1.
- LHU addr=0x2000, mem_data_i=0x8001_7777, immediate ack -> sel=1100, wdata_o=0x00008001. SH addr=0x2002, store_data_i=0x0000BEEF -> mem_we_o=1, sel=0011, mem_data_o=0xBEEFBEEF.
- LW addr=0x3002 -> adel_o=1, wreg_o=0, stall_req_o=0, no req. SW addr=0x3001 -> ades_o=1, no req.
- MAX_WAIT=4, LW with ack never asserted -> req drops after 4 WAIT cycles; bus_err_o=1 for 1 cycle in DONE; wreg_o=0; FSM returns to IDLE.
- rst asserted during WAIT, then ack arrives the cycle after -> mem_req_o=0 after the edge, ack ignored, FSM IDLE, all outputs 0 while rst=1.

Source files
------------

// File: rtl/mem_ls_stage.sv
// MEM pipeline stage: passes ALU/HI-LO results through and runs loads/stores over a
// req/ack data bus, with big-endian lane select, misalignment traps and a bus timeout.
module mem_ls_stage #(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           wdata_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  whilo_i,
    input  logic [31:0]           hi_i,
    input  logic [31:0]           lo_i,
    input  logic [3:0]            mem_op_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [31:0]           store_data_i,
    output logic [31:0]           wdata_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic                  whilo_o,
    output logic [31:0]           hi_o,
    output logic [31:0]           lo_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [3:0]            mem_sel_o,
    output logic [31:0]           mem_data_o,
    input  logic                  mem_ack_i,
    input  logic [31:0]           mem_data_i,
    output logic                  stall_req_o,
    output logic                  adel_o,
    output logic                  ades_o,
    output logic                  bus_err_o,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        timeout;
    logic [31:0] rd_data;
    logic [3:0]  op_q;
    logic [1:0]  off_q;

    logic        is_load, is_store, is_byte, is_half, is_word, misaligned, start;
    logic [3:0]  sel_nxt;
    logic [31:0] sdata_nxt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic        op_q_is_load;

    assign dbg_state = state;

    always_comb begin
        is_load    = (mem_op_i >= 4'd1) && (mem_op_i <= 4'd5);
        is_store   = (mem_op_i >= 4'd6) && (mem_op_i <= 4'd8);
        is_byte    = (mem_op_i == 4'd1) || (mem_op_i == 4'd2) || (mem_op_i == 4'd6);
        is_half    = (mem_op_i == 4'd3) || (mem_op_i == 4'd4) || (mem_op_i == 4'd7);
        is_word    = (mem_op_i == 4'd5) || (mem_op_i == 4'd8);
        misaligned = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
        start      = (state == IDLE) && (is_load || is_store) && !misaligned;

        // Big-endian lanes: byte offset 0 is the most significant byte.
        sel_nxt   = 4'b1111;
        sdata_nxt = store_data_i;
        if (is_byte) begin
            sel_nxt   = 4'b1000 >> mem_addr_i[1:0];
            sdata_nxt = {4{store_data_i[7:0]}};
        end else if (is_half) begin
            sel_nxt   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            sdata_nxt = {2{store_data_i[15:0]}};
        end
    end

    always_comb begin
        ld_byte = rd_data[31:24];
        case (off_q)
            2'd1:    ld_byte = rd_data[23:16];
            2'd2:    ld_byte = rd_data[15:8];
            2'd3:    ld_byte = rd_data[7:0];
            default: ld_byte = rd_data[31:24];
        endcase
        ld_half = off_q[1] ? rd_data[15:0] : rd_data[31:16];
        case (op_q)
            4'd1:    ld_val = {{24{ld_byte[7]}}, ld_byte};
            4'd2:    ld_val = {24'h0, ld_byte};
            4'd3:    ld_val = {{16{ld_half[15]}}, ld_half};
            4'd4:    ld_val = {16'h0, ld_half};
            default: ld_val = rd_data;
        endcase
        op_q_is_load = (op_q >= 4'd1) && (op_q <= 4'd5);
    end

    // Bus handshake: mem_req_o rises together with valid we/addr/sel/data, and all of
    // them hold steady until the cycle mem_ack_i is seen (read data is valid in that
    // same cycle) or the wait budget runs out; req drops at the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            timeout    <= 1'b0;
            rd_data    <= 32'h0;
            op_q       <= 4'd0;
            off_q      <= 2'd0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_sel_o  <= 4'b0000;
            mem_data_o <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= is_store;
                        mem_addr_o <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                        mem_sel_o  <= sel_nxt;
                        mem_data_o <= sdata_nxt;
                        op_q       <= mem_op_i;
                        off_q      <= mem_addr_i[1:0];
                        wait_cnt   <= 8'd0;
                        timeout    <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack_i) begin
                        rd_data   <= mem_data_i;
                        mem_req_o <= 1'b0;
                        state     <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        mem_req_o <= 1'b0;
                        timeout   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    // The pipeline advances at this edge, so the op is never reissued.
                    timeout <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wdata_o     = wdata_i;
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        whilo_o     = whilo_i;
        hi_o        = hi_i;
        lo_o        = lo_i;
        stall_req_o = start || (state == WAIT);
        adel_o      = (state == IDLE) && is_load && misaligned;
        ades_o      = (state == IDLE) && is_store && misaligned;
        bus_err_o   = (state == DONE) && timeout;
        if (adel_o) begin
            wreg_o = 1'b0;
        end
        if ((state == DONE) && op_q_is_load) begin
            wdata_o = ld_val;
            wreg_o  = wreg_i && !timeout;
        end
        if (rst) begin
            wdata_o     = 32'h0;
            wd_o        = '0;
            wreg_o      = 1'b0;
            whilo_o     = 1'b0;
            hi_o        = 32'h0;
            lo_o        = 32'h0;
            stall_req_o = 1'b0;
            adel_o      = 1'b0;
            ades_o      = 1'b0;
            bus_err_o   = 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_ls_stage.sv
// Bench for mem_ls_stage: randomized instruction stream against a reference model,
// with a bus responder and a retire monitor that pop expectations from queues.
module tb_mem_ls_stage;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wdata_i, hi_i, lo_i, store_data_i, mem_addr_i, mem_data_i;
    logic [4:0]  wd_i;
    logic        wreg_i, whilo_i, mem_ack_i;
    logic [3:0]  mem_op_i;
    logic [31:0] wdata_o, hi_o, lo_o, mem_addr_o, mem_data_o;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, mem_req_o, mem_we_o, stall_req_o, adel_o, ades_o, bus_err_o;
    logic [3:0]  mem_sel_o;
    logic [1:0]  dbg_state;
    bit          late_ack;

    mem_ls_stage #(.ADDR_W(32), .REG_ADDR_W(5), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .wdata_i(wdata_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i), .mem_op_i(mem_op_i),
        .mem_addr_i(mem_addr_i), .store_data_i(store_data_i), .wdata_o(wdata_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i),
        .mem_data_i(mem_data_i), .stall_req_o(stall_req_o), .adel_o(adel_o),
        .ades_o(ades_o), .bus_err_o(bus_err_o), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] wdata;
        logic        chk_wdata;
        logic [4:0]  wd;
        logic        wreg;
        logic        chk_wreg;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        adel;
        logic        ades;
        logic        bus_err;
        logic [7:0]  lat;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  delay;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2 || op == 4'd6) return 1;
        if (op == 4'd3 || op == 4'd4 || op == 4'd7) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_ref(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [7:0] b [4];
        int off;
        int val;
        for (int i = 0; i < 4; i++) b[i] = rdata[31-8*i -: 8];
        off = int'(addr[1:0]);
        case (op)
            4'd1:    val = int'($signed(b[off]));
            4'd2:    val = int'(b[off]);
            4'd3:    val = int'($signed({b[off], b[off+1]}));
            4'd4:    val = int'({b[off], b[off+1]});
            default: val = int'(rdata);
        endcase
        return 32'(val);
    endfunction

    function automatic logic [3:0] sel_ref(input int sz, input int off);
        logic [3:0] s;
        s = 4'b0000;
        for (int k = 0; k < sz; k++) s[3-off-k] = 1'b1;
        return s;
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int delay);
        exp_t e;
        bus_t b;
        bit   is_ld, is_st, mis, done;
        int   sz, waits;
        is_ld = (op >= 4'd1) && (op <= 4'd5);
        is_st = (op >= 4'd6) && (op <= 4'd8);
        sz    = op_size(op);
        mis   = (is_ld || is_st) && ((addr % sz) != 0);

        wdata_i      = $urandom;
        wd_i         = 5'($urandom_range(0, 31));
        wreg_i       = 1'($urandom_range(0, 1));
        whilo_i      = 1'($urandom_range(0, 1));
        hi_i         = $urandom;
        lo_i         = $urandom;
        mem_op_i     = op;
        mem_addr_i   = addr;
        store_data_i = sdata;

        e           = '0;
        e.wdata     = wdata_i;
        e.chk_wdata = 1'b1;
        e.wd        = wd_i;
        e.wreg      = wreg_i;
        e.chk_wreg  = 1'b1;
        e.whilo     = whilo_i;
        e.hi        = hi_i;
        e.lo        = lo_i;
        e.lat       = 8'd1;
        if (mis) begin
            e.adel      = is_ld;
            e.ades      = is_st;
            e.chk_wdata = 1'b0;
            if (is_ld) e.wreg = 1'b0;
            else e.chk_wreg = 1'b0;
        end else if (is_ld || is_st) begin
            waits     = (delay < MAX_WAIT) ? delay + 1 : MAX_WAIT;
            e.lat     = 8'(2 + waits);
            e.bus_err = (delay >= MAX_WAIT);
            if (is_st) begin
                e.chk_wdata = 1'b0;
                e.chk_wreg  = 1'b0;
            end else if (e.bus_err) begin
                e.wreg      = 1'b0;
                e.chk_wdata = 1'b0;
            end else begin
                e.wdata = load_ref(op, addr, rdata);
            end
            b.we    = is_st;
            b.addr  = addr & ~32'h3;
            b.sel   = sel_ref(sz, int'(addr[1:0]));
            b.wdata = (sz == 1) ? {4{sdata[7:0]}} : (sz == 2) ? {2{sdata[15:0]}} : sdata;
            b.rdata = rdata;
            b.delay = 8'(delay);
            bus_q.push_back(b);
        end
        exp_q.push_back(e);

        done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!stall_req_o) begin
                done = 1'b1;
                break;
            end
        end
        check("retire_within_bound", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_comb_zero(input string pfx);
        check({pfx, "_wdata"}, wdata_o, 32'h0);
        check({pfx, "_wd"}, 32'(wd_o), 32'h0);
        check({pfx, "_wreg"}, 32'(wreg_o), 32'h0);
        check({pfx, "_whilo"}, 32'(whilo_o), 32'h0);
        check({pfx, "_hi"}, hi_o, 32'h0);
        check({pfx, "_lo"}, lo_o, 32'h0);
        check({pfx, "_stall"}, 32'(stall_req_o), 32'h0);
        check({pfx, "_adel"}, 32'(adel_o), 32'h0);
        check({pfx, "_ades"}, 32'(ades_o), 32'h0);
        check({pfx, "_bus_err"}, 32'(bus_err_o), 32'h0);
    endtask

    // ---------------- bus responder ----------------
    initial begin : responder
        bit   active;
        int   cnt;
        bus_t b;
        active     = 1'b0;
        cnt        = 0;
        b          = '0;
        mem_ack_i  = 1'b0;
        mem_data_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (active && !mem_req_o) active = 1'b0;
            if (!active && mem_req_o) begin
                check("bus_req_expected", 32'(bus_q.size() != 0), 32'd1);
                if (bus_q.size() != 0) begin
                    b      = bus_q.pop_front();
                    active = 1'b1;
                    cnt    = 0;
                end
            end
            if (active) begin
                check("bus_we", 32'(mem_we_o), 32'(b.we));
                check("bus_addr", mem_addr_o, b.addr);
                check("bus_sel", 32'(mem_sel_o), 32'(b.sel));
                if (b.we) check("bus_wdata", mem_data_o, b.wdata);
                if (cnt == int'(b.delay)) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = b.rdata;
                end else begin
                    mem_ack_i  = 1'b0;
                    mem_data_i = $urandom;
                end
                cnt++;
            end else begin
                mem_ack_i  = late_ack;
                mem_data_i = $urandom;
                late_ack   = 1'b0;
            end
        end
    end

    // ---------------- retire monitor ----------------
    initial begin : monitor
        int   cyc;
        exp_t e;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc = 0;
            end else begin
                cyc++;
                if (!stall_req_o) begin
                    check("retire_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("latency", 32'(cyc), 32'(e.lat));
                        check("wd", 32'(wd_o), 32'(e.wd));
                        check("whilo", 32'(whilo_o), 32'(e.whilo));
                        check("hi", hi_o, e.hi);
                        check("lo", lo_o, e.lo);
                        check("adel", 32'(adel_o), 32'(e.adel));
                        check("ades", 32'(ades_o), 32'(e.ades));
                        check("bus_err", 32'(bus_err_o), 32'(e.bus_err));
                        if (e.chk_wdata) check("wdata", wdata_o, e.wdata);
                        if (e.chk_wreg) check("wreg", 32'(wreg_o), 32'(e.wreg));
                    end
                    cyc = 0;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [31:0] addr;
        bus_t        b;
        late_ack     = 1'b0;
        rst          = 1'b1;
        wdata_i      = 32'hDEADBEEF;
        wd_i         = 5'd7;
        wreg_i       = 1'b1;
        whilo_i      = 1'b1;
        hi_i         = 32'h0000000A;
        lo_i         = 32'h0000000B;
        mem_op_i     = 4'd5;
        mem_addr_i   = 32'h00000002;
        store_data_i = 32'h12345678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_comb_zero("rst");
        check("rst_req", 32'(mem_req_o), 32'h0);
        check("rst_we", 32'(mem_we_o), 32'h0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_sel", 32'(mem_sel_o), 32'h0);
        check("rst_data", mem_data_o, 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(4'd0, 32'h0000_1000, 32'h0, 32'h0, 0);
        issue(4'd1, 32'h0000_1003, 32'h0, 32'h0000_00F0, 1);
        issue(4'd4, 32'h0000_2000, 32'h0, 32'h8001_7777, 0);
        issue(4'd7, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0);
        issue(4'd5, 32'h0000_3002, 32'h0, 32'h0, 0);
        issue(4'd8, 32'h0000_3001, 32'h1111_2222, 32'h0, 0);
        issue(4'd5, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 10);
        check("idle_after_timeout", 32'(dbg_state), 32'h0);
        issue(4'd5, 32'h0000_0040, 32'h0, 32'h1357_9BDF, MAX_WAIT - 1);
        issue(4'd2, 32'h0000_0041, 32'h0, 32'h0080_0000, MAX_WAIT);
        issue(4'd3, 32'h0000_0042, 32'h0, 32'h1234_8001, 0);
        issue(4'd6, 32'h0000_0043, 32'h0000_00A5, 32'h0, 2);
        issue(4'd12, 32'h0000_0001, 32'h0, 32'h0, 0);

        // Reset while the bus access is waiting, with an ack arriving one cycle late.
        wdata_i      = $urandom;
        hi_i         = $urandom;
        lo_i         = $urandom;
        mem_op_i     = 4'd5;
        mem_addr_i   = 32'h0000_0500;
        b            = '0;
        b.addr       = 32'h0000_0500;
        b.sel        = 4'b1111;
        b.delay      = 8'd99;
        bus_q.push_back(b);
        @(posedge clk);
        #1;
        check("mid_req_before_rst", 32'(mem_req_o), 32'd1);
        check("mid_state_wait", 32'(dbg_state), 32'd1);
        rst      = 1'b1;
        late_ack = 1'b1;
        @(negedge clk);
        check_comb_zero("mid_rst");
        @(posedge clk);
        #1;
        check("mid_req_dropped", 32'(mem_req_o), 32'h0);
        check("mid_state_idle", 32'(dbg_state), 32'h0);
        rst = 1'b0;
        issue(4'd0, 32'h0, 32'h0, 32'h0, 0);
        check("late_ack_req", 32'(mem_req_o), 32'h0);
        check("late_ack_state", 32'(dbg_state), 32'h0);

        for (int t = 0; t < 150; t++) begin
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr = addr & ~32'h3;
            if ($urandom_range(0, 1) != 0) addr = addr | 32'($urandom_range(0, 3));
            issue(4'($urandom_range(0, 15)), addr, $urandom, $urandom,
                  int'($urandom_range(0, MAX_WAIT + 1)));
        end

        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("bus_q_drained", 32'(bus_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end
endmodule
